// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine and its subtract datapath.
package gcd_pkg;

    localparam int WIDTH       = 8;
    localparam int OPERAND_MAX = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when v lies inside the positive operand range accepted by the engine.
    function automatic logic operand_ok(input logic [WIDTH-1:0] v);
        return v <= WIDTH'(OPERAND_MAX);
    endfunction

endpackage

// File: rtl/gcd_dp.sv
// Operand registers, swap muxes, overflow-zeroing subtractor and compare flags.
module gcd_sub
    import gcd_pkg::*;
(
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH-1:0] raw;
    logic             ovf;

    assign raw  = in1 - in2;
    // Signed overflow: operands differ in sign and the result sign differs from in1.
    assign ovf  = (in1[WIDTH-1] != in2[WIDTH-1]) && (raw[WIDTH-1] != in1[WIDTH-1]);
    assign diff = ovf ? '0 : raw;

endmodule

module gcd_dp
    import gcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             swap,
    input  logic             wr_x,
    input  logic             wr_y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] x,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] diff;

    assign eq = (x == y);
    assign gt = (x > y);

    // swap puts the larger register on in1 so the difference stays non-negative.
    assign in1 = swap ? y : x;
    assign in2 = swap ? x : y;

    gcd_sub u_sub (
        .in1  (in1),
        .in2  (in2),
        .diff (diff)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= a;
            y <= b;
        end else begin
            if (wr_x) x <= diff;
            if (wr_y) y <= diff;
        end
    end

endmodule

// File: rtl/gcd_ctrl.sv
// Sequencing FSM for the subtractive GCD engine; drives gcd_dp and owns the outputs.
module gcd_ctrl
    import gcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_t           state;
    logic             ops_ok;
    logic             has_zero;
    logic             load;
    logic             swap;
    logic             wr_x;
    logic             wr_y;
    logic [WIDTH-1:0] x;
    logic             eq;
    logic             gt;

    assign ops_ok   = operand_ok(a_in) && operand_ok(b_in);
    assign has_zero = (a_in == '0) || (b_in == '0);

    assign load = (state == IDLE) && start && ops_ok && !has_zero;
    assign swap = !gt;
    assign wr_x = (state == RUN) && gt;
    assign wr_y = (state == RUN) && !gt && !eq;

    gcd_dp u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .swap  (swap),
        .wr_x  (wr_x),
        .wr_y  (wr_y),
        .a     (a_in),
        .b     (b_in),
        .x     (x),
        .eq    (eq),
        .gt    (gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!ops_ok) begin
                            err    <= 1'b1;
                            result <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (has_zero) begin
                            err    <= 1'b0;
                            result <= a_in | b_in;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (eq) begin
                        result <= x;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: vector table, hand-written corner sequences, random jobs.
module tb_gcd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;

    int n_tests;
    int n_fail;

    gcd_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       err;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by division; subtraction steps = sum of quotients minus the final one.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic e, output int lat);
        int x, y, q, k;
        if (a > 8'd127 || b > 8'd127) begin
            r = 8'd0; e = 1'b1; lat = 1;
        end else if (a == 0 || b == 0) begin
            r = a | b; e = 1'b0; lat = 1;
        end else begin
            x = a; y = b; k = 0;
            while (y != 0) begin
                k += x / y;
                q = x % y;
                x = y;
                y = q;
            end
            r = x[7:0]; e = 1'b0; lat = k + 1;
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge following done.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] prev,
                           output logic [7:0] res, output logic e, output int lat,
                           output bit busy_ok, output bit hold_ok);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (result !== prev) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        res = result; e = err;
        if (!busy) busy_ok = 1'b0;
        @(posedge clk); #1;
        if (done || busy) busy_ok = 1'b0;
    endtask

    task automatic job_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] prev, input logic [7:0] er, input logic ee,
                             input int el);
        logic [7:0] r;
        logic       e;
        int         l;
        bit         bok, hok;
        run_job(a, b, prev, r, e, l, bok, hok);
        check({tag, " latency"}, l, el);
        check({tag, " result"}, r, er);
        check({tag, " err"}, e, ee);
        check({tag, " busy/done window"}, bok, 1'b1);
        check({tag, " result hold"}, hok, 1'b1);
    endtask

    vec_t       vecs [8];
    logic [7:0] last;
    logic [7:0] mr;
    logic       me;
    int         ml;

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle no done", done, 0);

        vecs[0] = '{a: 8'd48,  b: 8'd18,  res: 8'd6,  err: 1'b0, lat: 6};
        vecs[1] = '{a: 8'd27,  b: 8'd27,  res: 8'd27, err: 1'b0, lat: 2};
        vecs[2] = '{a: 8'd127, b: 8'd1,   res: 8'd1,  err: 1'b0, lat: 128};
        vecs[3] = '{a: 8'd0,   b: 8'd35,  res: 8'd35, err: 1'b0, lat: 1};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   res: 8'd0,  err: 1'b0, lat: 1};
        vecs[5] = '{a: 8'd200, b: 8'd5,   res: 8'd0,  err: 1'b1, lat: 1};
        vecs[6] = '{a: 8'd1,   b: 8'd127, res: 8'd1,  err: 1'b0, lat: 128};
        vecs[7] = '{a: 8'd5,   b: 8'd128, res: 8'd0,  err: 1'b1, lat: 1};

        // Back-to-back: each job starts in the first IDLE cycle after the previous done.
        last = 8'd0;
        for (int i = 0; i < 8; i++) begin
            job_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, last,
                      vecs[i].res, vecs[i].err, vecs[i].lat);
            last = vecs[i].res;
        end

        // Load a nonzero result so the reset clear below is observable.
        job_check("pre-reset", 8'd48, 8'd18, last, 8'd6, 1'b0, 6);
        a_in = 8'd48; b_in = 8'd18; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort err", err, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done) check("abort spurious done", done, 0);
        end
        @(posedge clk); #1;
        job_check("after reset", 8'd48, 8'd18, 8'd0, 8'd6, 1'b0, 6);

        // start while busy is ignored and not queued.
        begin
            int l;
            a_in = 8'd100; b_in = 8'd75; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            l = 0;
            for (int c = 1; c <= 200; c++) begin
                if (c == 2) begin a_in = 8'd9; b_in = 8'd3; start = 1'b1; end
                if (c == 3) start = 1'b0;
                if (done) begin l = c; break; end
                @(posedge clk); #1;
            end
            check("busy-start latency", l, 5);
            check("busy-start result", result, 25);
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (done || busy) check("busy-start not queued", {busy, done}, 0);
            end
            last = 8'd25;
        end

        // Random jobs against the reference model, mostly in range with some error operands.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 127));
            rb = 8'($urandom_range(1, 127));
            if ($urandom_range(0, 9) == 0) ra[7] = 1'b1;
            if ($urandom_range(0, 9) == 0) rb = 8'd0;
            model(ra, rb, mr, me, ml);
            job_check($sformatf("rand%0d(%0d,%0d)", i, ra, rb), ra, rb, last, mr, me, ml);
            last = mr;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
